// File: rtl/jt6295_pkg.sv
// rtl/jt6295_pkg.sv - shared types and constants for the jt6295 command sequencer
package jt6295_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FETCH = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  // Phrase table layout: one 8-byte slot per phrase, 6 bytes used
  localparam int HDR_STRIDE = 8;
  localparam int HDR_BYTES  = 6;

  // CPU command byte fields
  localparam int CMD_PHRASE = 7;
  localparam int STOP_MSB   = 6;
  localparam int STOP_LSB   = 3;

  // ROM byte address of a phrase header; wraps modulo 2^18
  function automatic logic [17:0] hdr_base_addr(input logic [17:0] base, input logic [6:0] phrase);
    return base + (18'(phrase) << $clog2(HDR_STRIDE));
  endfunction

endpackage

// File: rtl/jt6295_cmd_seq_if.sv
// rtl/jt6295_cmd_seq_if.sv - CPU write port and header ROM port of the command sequencer
interface jt6295_cmd_seq_if;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic        cmd_busy;
  logic        rom_cs;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;

  // CPU and ROM side
  modport master (
    output cpu_we, cpu_din, rom_data, rom_ok,
    input  cmd_busy, rom_cs, rom_addr
  );

  // Sequencer side
  modport slave (
    input  cpu_we, cpu_din, rom_data, rom_ok,
    output cmd_busy, rom_cs, rom_addr
  );
endinterface

// File: rtl/jt6295_hdr_fetch.sv
// rtl/jt6295_hdr_fetch.sv - reads the 6-byte phrase header from ROM and assembles start/stop addresses
module jt6295_hdr_fetch
  import jt6295_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [17:0] base,
  output logic        rom_cs,
  output logic [17:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic [17:0] start_addr,
  output logic [17:0] stop_addr,
  output logic        done
);

  logic [2:0]  k;
  logic        skip;     // rom_ok is stale in the first cycle after rom_addr moves
  logic [17:0] start_sr; // bytes 0..2, MSB first; bits above 17 fall off
  logic [9:0]  stop_sr;  // bytes 3..4; byte 5 joins directly on the last transfer

  assign rom_addr = base + 18'(k);

  // Byte counter, ROM handshake and address assembly; outputs update only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_cs     <= 1'b0;
      k          <= 3'd0;
      skip       <= 1'b0;
      start_sr   <= 18'd0;
      stop_sr    <= 10'd0;
      start_addr <= 18'd0;
      stop_addr  <= 18'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        rom_cs <= 1'b1;
        k      <= 3'd0;
        skip   <= 1'b1;
      end else if (rom_cs) begin
        if (skip) begin
          skip <= 1'b0;
        end else if (rom_ok) begin
          if (k < 3'(HDR_BYTES / 2)) begin
            start_sr <= {start_sr[9:0], rom_data};
          end else begin
            stop_sr <= {stop_sr[1:0], rom_data};
          end
          if (k == 3'(HDR_BYTES - 1)) begin
            rom_cs     <= 1'b0;
            done       <= 1'b1;
            start_addr <= start_sr;
            stop_addr  <= {stop_sr, rom_data};
          end else begin
            k    <= k + 3'd1;
            skip <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/jt6295_cmd_seq.sv
// rtl/jt6295_cmd_seq.sv - MSM6295-style command decode, header fetch and slot-aligned issue; option JT6295_PHRASE_CHECK_EN
module jt6295_cmd_seq
  import jt6295_pkg::*;
#(
  parameter logic [17:0] HDR_BASE = 18'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen4,
  input  logic            zero,
  input  logic [3:0]      busy,
  jt6295_cmd_seq_if.slave bus,
  output logic [17:0]     start_addr,
  output logic [17:0]     stop_addr,
  output logic [3:0]      att,
  output logic [3:0]      start,
  output logic [3:0]      stop
);

  state_t     state, state_nx;
  logic [6:0] phrase;
  logic [3:0] mask;
  logic [3:0] att_r;
  logic [3:0] start_r;
  logic [3:0] stop_r;
  logic [3:0] stop_wr;
  logic       slot;
  logic       fetch_go;
  logic       done;
  logic       bad_hdr;

  // The engine captures requests on the channel-0 slot edge
  assign slot = cen4 & zero;

  // Stop bytes are accepted in every state except ARMED, where the byte is the channel mask
  assign stop_wr = (bus.cpu_we && !bus.cpu_din[CMD_PHRASE] && state != ST_ARMED)
                   ? bus.cpu_din[STOP_MSB:STOP_LSB] : 4'd0;

`ifdef JT6295_PHRASE_CHECK_EN
  logic bad_phrase;

  assign bad_hdr = (stop_addr <= start_addr);

  // Sticky record of a rejected header
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_phrase <= 1'b0;
    end else if (done && bad_hdr) begin
      bad_phrase <= 1'b1;
    end
  end
`else
  assign bad_hdr = 1'b0;
`endif

  jt6295_hdr_fetch u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (fetch_go),
    .base       (hdr_base_addr(HDR_BASE, phrase)),
    .rom_cs     (bus.rom_cs),
    .rom_addr   (bus.rom_addr),
    .rom_data   (bus.rom_data),
    .rom_ok     (bus.rom_ok),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .done       (done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.cpu_we && bus.cpu_din[CMD_PHRASE]) state_nx = ST_ARMED;
      ST_ARMED: if (bus.cpu_we) state_nx = (bus.cpu_din[7:4] != 4'd0) ? ST_FETCH : ST_IDLE;
      ST_FETCH: if (done) state_nx = ST_ISSUE;
      ST_ISSUE: if (slot || bad_hdr) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.cmd_busy = (state == ST_FETCH) || (state == ST_ISSUE);
    fetch_go     = (state == ST_ARMED) && bus.cpu_we && (bus.cpu_din[7:4] != 4'd0);
  end

  // Command registers and pending start/stop masks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phrase  <= 7'd0;
      mask    <= 4'd0;
      att_r   <= 4'd0;
      att     <= 4'd0;
      start_r <= 4'd0;
      stop_r  <= 4'd0;
    end else begin
      if (state == ST_IDLE && bus.cpu_we && bus.cpu_din[CMD_PHRASE]) begin
        phrase <= bus.cpu_din[6:0];
      end
      if (state == ST_ARMED && bus.cpu_we) begin
        mask  <= bus.cpu_din[7:4];
        att_r <= bus.cpu_din[3:0];
      end
      // busy is sampled as the FSM enters ISSUE; a bad header never asks for a start
      if (state == ST_FETCH && done) begin
        start_r <= bad_hdr ? 4'd0 : (mask & ~busy);
        att     <= att_r;
      end else if (slot) begin
        start_r <= 4'd0;
      end
      // A stop written on the capture edge survives for the following slot
      stop_r <= slot ? stop_wr : (stop_r | stop_wr);
    end
  end

  // Stop wins over start for the same channel in the same slot
  assign start = start_r & ~stop_r;
  assign stop  = stop_r;

endmodule

// File: tb/tb_jt6295_cmd_seq.sv
// tb/tb_jt6295_cmd_seq.sv - scoreboard bench for jt6295_cmd_seq with a behavioural ROM and slot model
module tb_jt6295_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen4 = 1'b0;
  logic        zero = 1'b0;
  logic [3:0]  busy = 4'd0;
  logic [17:0] start_addr, stop_addr;
  logic [3:0]  att, start, stop;

  jt6295_cmd_seq_if bus();

  jt6295_cmd_seq #(.HDR_BASE(18'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen4       (cen4),
    .zero       (zero),
    .busy       (busy),
    .bus        (bus),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .att        (att),
    .start      (start),
    .stop       (stop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  sp;
    logic [3:0]  at;
    logic [17:0] sa;
    logic [17:0] ea;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rom [0:1023];
  logic       hold_last = 1'b0;
  int         force_dly = -1;

  task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] d);
    bus.cpu_we  = 1'b1;
    bus.cpu_din = d;
    tick();
    bus.cpu_we  = 1'b0;
  endtask

  // Engine timing: one cen4 every 2 clocks, zero high for the channel-0 slot of four
  initial begin
    int p;
    p = 0;
    forever begin
      @(posedge clk);
      #1;
      p    = (p + 1) % 8;
      cen4 = (p % 2 == 1);
      zero = (p < 2);
    end
  end

  // ROM: rom_ok after a random 0..5 cycle delay once the address settles
  initial begin
    logic [17:0] last;
    int cnt, dly;
    last = '1; cnt = 0; dly = 0;
    bus.rom_ok = 1'b0;
    bus.rom_data = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.rom_cs) begin
        last = '1;
        bus.rom_ok = 1'b0;
      end else begin
        if (bus.rom_addr != last) begin
          last = bus.rom_addr;
          cnt  = 0;
          dly  = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 5));
        end else begin
          cnt++;
        end
        bus.rom_data = rom[bus.rom_addr[9:0]];
        bus.rom_ok   = (cnt >= dly) && !(hold_last && bus.rom_addr[2:0] == 3'd5);
      end
    end
  end

  // Monitor: every slot that presents a request is checked against the head of the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cen4 && zero && (start != 4'd0 || stop != 4'd0)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slot start=%h stop=%h", start, stop);
        end else begin
          e = exp_q.pop_front();
          chk("slot_start", 18'(start), 18'(e.st));
          chk("slot_stop", 18'(stop), 18'(e.sp));
          if (e.st != 4'd0) begin
            chk("slot_att", 18'(att), 18'(e.at));
            chk("slot_start_addr", start_addr, e.sa);
            chk("slot_stop_addr", stop_addr, e.ea);
          end
        end
      end
      if (rst_n && bus.rom_cs) chk("cmd_busy_in_fetch", 18'(bus.cmd_busy), 18'd1);
    end
  end

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !bus.cmd_busy) break;
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || bus.cmd_busy) begin
      errors++;
      $display("FAIL %s pending=%0d cmd_busy=%0d want 0/0", nm, exp_q.size(), bus.cmd_busy);
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_start"}, 18'(start), 18'd0);
    chk({nm, "_stop"}, 18'(stop), 18'd0);
    chk({nm, "_att"}, 18'(att), 18'd0);
    chk({nm, "_start_addr"}, start_addr, 18'd0);
    chk({nm, "_stop_addr"}, stop_addr, 18'd0);
    chk({nm, "_cmd_busy"}, 18'(bus.cmd_busy), 18'd0);
    chk({nm, "_rom_cs"}, 18'(bus.rom_cs), 18'd0);
    chk({nm, "_rom_addr"}, bus.rom_addr, 18'd0);
  endtask

  // mode 0: plain; 1: phrase byte mid-fetch; 2: stop byte stopv written just before issue
  task automatic start_cmd(input logic [6:0] ph, input logic [3:0] m, input logic [3:0] a,
                           input logic [3:0] bz, input int mode, input logic [3:0] stopv);
    exp_t e;
    int b;
    logic [23:0] s24, e24;
    logic [3:0] sp;
    b   = int'(ph) * 8;
    s24 = {rom[b], rom[b + 1], rom[b + 2]};
    e24 = {rom[b + 3], rom[b + 4], rom[b + 5]};
    sp  = (mode == 2 && m != 4'd0) ? stopv : 4'd0;
    e.sa = s24[17:0];
    e.ea = e24[17:0];
    e.at = a;
    e.sp = sp;
    e.st = m & ~bz & ~sp;
`ifdef JT6295_PHRASE_CHECK_EN
    if (e.ea <= e.sa) e.st = 4'd0;
`endif
    if (m != 4'd0 && (e.st != 4'd0 || e.sp != 4'd0)) exp_q.push_back(e);
    busy = bz;
    if (mode == 2 && m != 4'd0) hold_last = 1'b1;
    cpu_wr({1'b1, ph});
    cpu_wr({m, a});
    if (mode == 1) begin
      tick();
      cpu_wr({1'b1, 7'($urandom)});
    end else if (mode == 2 && m != 4'd0) begin
      for (int i = 0; i < 200; i++) begin
        if (bus.rom_cs && bus.rom_addr[2:0] == 3'd5) break;
        tick();
      end
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (cen4 && zero) break;
      end
      tick();
      cpu_wr({1'b0, stopv, 3'($urandom)});
      hold_last = 1'b0;
    end
    wait_drain("start_cmd_drain");
    busy = 4'd0;
  endtask

  task automatic stop_cmd(input logic [3:0] bits, input int dly);
    exp_t e;
    e = '0;
    e.sp = bits;
    repeat (dly) tick();
    exp_q.push_back(e);
    cpu_wr({1'b0, bits, 3'($urandom)});
    wait_drain("stop_cmd_drain");
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    bus.cpu_we  = 1'b0;
    bus.cpu_din = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;
    repeat (3) tick();

    // Phrase 1 header 00_01_00 / 00_01_FF, slow ROM
    {rom[8], rom[9], rom[10], rom[11], rom[12], rom[13]} = 48'h00_01_00_00_01_FF;
    force_dly = 5;
    start_cmd(7'd1, 4'h1, 4'hA, 4'h0, 1, 4'h0);
    force_dly = -1;

    // Busy channels are left alone
    {rom[16], rom[17], rom[18], rom[19], rom[20], rom[21]} = 48'h00_20_00_01_30_00;
    start_cmd(7'd2, 4'hF, 4'h3, 4'b0011, 0, 4'h0);

    // Stop-only command 8'h48
    stop_cmd(4'b1001, 0);

    // Stop for ch0 arriving during the fetch of a ch0 start
    {rom[24], rom[25], rom[26], rom[27], rom[28], rom[29]} = 48'h03_00_40_03_10_00;
    start_cmd(7'd3, 4'h1, 4'h5, 4'h0, 2, 4'b0001);

    // Mask 0 never fetches
    start_cmd(7'd4, 4'h0, 4'h7, 4'h0, 0, 4'h0);

    // Stop written on the capture edge of an earlier stop is kept for the next slot
    e = '0; e.sp = 4'b0100; exp_q.push_back(e);
    cpu_wr(8'b0_0100_000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (zero && !cen4) break;
    end
    e = '0; e.sp = 4'b0010; exp_q.push_back(e);
    @(posedge clk);
    #1;
    cpu_wr(8'b0_0010_000);
    wait_drain("slot_edge_stop_drain");

    // Reset while fetching byte 3
    busy = 4'd0;
    cpu_wr(8'h85);
    cpu_wr(8'hF2);
    for (int i = 0; i < 200; i++) begin
      if (bus.rom_cs && bus.rom_addr[2:0] == 3'd3) break;
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk_reset_outs("mid_fetch_reset");
    rst_n = 1'b1;
    repeat (2) tick();
    {rom[48], rom[49], rom[50], rom[51], rom[52], rom[53]} = 48'h00_00_10_3F_FF_FF;
    start_cmd(7'd6, 4'hC, 4'h9, 4'h0, 0, 4'h0);

    // Randomised commands
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        stop_cmd(4'($urandom_range(1, 15)), int'($urandom_range(0, 9)));
      end else begin
        start_cmd(7'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 2)), 4'($urandom_range(1, 15)));
      end
    end

    chk("final_queue_empty", 18'(exp_q.size()), 18'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
